// File: rtl/uart_pkg.sv
// Shared UART definitions.
// Holds the frame constants and the receiver state encoding. The transmitter
// can import the same frame constants.
package uart_pkg;

  localparam int   UART_DATA_BITS  = 8;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Receiver FSM states. The encoding is fixed so that the debug state port
  // reads the same value in every build.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } uart_rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// RESET_VAL sets the level both flops take during reset. Use the line's idle
// level so that reset never produces a false edge downstream.
// Ports:
//   clk_i  - destination clock
//   rst_ni - asynchronous active-low reset
//   d_i    - asynchronous input
//   q_o    - synchronized output, two clk_i cycles of latency
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule : uart_sync2

// File: rtl/uart_rx.sv
// 8N1 UART receiver.
// Deserialises an idle-high line: one start bit (0), 8 data bits LSB first,
// and one stop bit (1), each clocks_per_bit cycles long. Each good byte is
// presented for one cycle on out_data/out_valid and added to a running
// 32-bit checksum. A stop bit sampled low raises a one-cycle out_error and
// the receiver then waits for the line to return high before it looks for
// another start bit.
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   rx          - serial line, asynchronous to clk, idle high
//   out_data    - last good byte, held until the next good byte
//   out_valid   - one-cycle pulse when out_data has just been updated
//   out_error   - one-cycle pulse on a framing error
//   out_sum     - sum of all good bytes since reset, modulo 2^32
//   dbg_state_o - current FSM state (uart_rx_state_t encoding)
// Handshake: out_valid has no ready. The consumer must take out_data in the
// cycle out_valid is high. out_valid and out_error are never high together.
module uart_rx
  import uart_pkg::*;
#(
  parameter int clocks_per_bit = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_error,
  output logic [31:0] out_sum,
  output logic [2:0]  dbg_state_o
);

  localparam int CW   = $clog2(clocks_per_bit);
  localparam int HALF = (clocks_per_bit - 1) / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(clocks_per_bit - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [2:0]    IDX_LAST = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  uart_sync2 #(
    .RESET_VAL(UART_IDLE_LEVEL)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  uart_rx_state_t state_q;
  logic [CW-1:0]  cnt_q;
  logic [2:0]     idx_q;
  logic [7:0]     shift_q;
  logic [7:0]     data_q;
  logic           valid_q;
  logic           error_q;
  logic [31:0]    sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      sum_q   <= '0;
    end else begin
      // The status outputs are pulses. They are cleared here and set below
      // only on the stop-sample cycle.
      valid_q <= 1'b0;
      error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!rx_s) begin
            state_q <= START;
            cnt_q   <= CNT_HALF;
          end
        end
        START: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (!rx_s) begin
            state_q <= DATA;
            cnt_q   <= CNT_LAST;
            idx_q   <= '0;
          end else begin
            // The line went high again before mid-bit, so this was a glitch.
            state_q <= IDLE;
          end
        end
        DATA: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            shift_q <= {rx_s, shift_q[7:1]};
            cnt_q   <= CNT_LAST;
            if (idx_q == IDX_LAST) begin
              state_q <= STOP;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end
        end
        STOP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (rx_s) begin
            // Returning to IDLE at the stop-bit centre lets a start bit that
            // follows with no idle gap still be detected.
            data_q  <= shift_q;
            valid_q <= 1'b1;
            sum_q   <= sum_q + {24'b0, shift_q};
            state_q <= IDLE;
          end else begin
            error_q <= 1'b1;
            state_q <= BREAK;
          end
        end
        BREAK: begin
          // A line held low gives one error and no further frames.
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data    = data_q;
  assign out_valid   = valid_q;
  assign out_error   = error_q;
  assign out_sum     = sum_q;
  assign dbg_state_o = state_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB = 4;
  localparam int H   = (CPB - 1) / 2;
  localparam int LAT = 3 + H + 9 * CPB;   // first-low edge -> pulse-visible edge

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx    = 1'b1;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_error;
  logic [31:0] out_sum;
  logic [2:0]  dbg_state;

  uart_rx #(.clocks_per_bit(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_error  (out_error),
    .out_sum    (out_sum),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;   // number of rising edges so far
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, expected bench to finish");
    $fatal(1, "watchdog");
  end

  // ---------------- monitor ----------------
  int         vcyc_q[$];
  logic [7:0] vdata_q[$];
  int         ecyc_q[$];
  int         both_cnt = 0;

  always @(negedge clk) begin
    if (out_valid) begin
      vcyc_q.push_back(cyc);
      vdata_q.push_back(out_data);
    end
    if (out_error) ecyc_q.push_back(cyc);
    if (out_valid && out_error) both_cnt++;
  end

  // ---------------- reference model state ----------------
  logic [31:0] ref_sum  = '0;
  logic [7:0]  ref_last = '0;
  logic [7:0]  exp_q[$];
  int          exp_cyc_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    vcyc_q.delete();
    vdata_q.delete();
    ecyc_q.delete();
  endtask

  // Acts as the transmitter: drives one full frame starting at a falling
  // edge and returns p, the first rising edge that samples the start bit.
  task automatic drive_frame(input logic [7:0] b, input logic stop, output int p);
    rx = 1'b0;
    p  = cyc + 1;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop;
    tick(CPB);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    ref_sum  = '0;
    ref_last = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    n_checks++;
    if ({out_valid, out_error, out_data, out_sum} !== 42'd0)
      $display("FAIL reset_outputs: got v=%b e=%b d=%h s=%h expected all zero",
               out_valid, out_error, out_data, out_sum);
    else n_pass++;
    n_checks++;
    if (dbg_state !== 3'd0) $display("FAIL reset_state: got %0d expected 0", dbg_state);
    else n_pass++;
    rst_n = 1'b1;
    tick(10);
    n_checks++;
    if (vcyc_q.size() != 0 || ecyc_q.size() != 0)
      $display("FAIL reset_no_pulse: got %0d valid %0d error expected 0 0",
               vcyc_q.size(), ecyc_q.size());
    else n_pass++;
  endtask

  task automatic test_single();
    int p;
    clear_mon();
    drive_frame(8'hA5, 1'b1, p);
    ref_sum += 32'hA5; ref_last = 8'hA5;
    tick(3);
    n_checks++;
    if (vcyc_q.size() != 1) $display("FAIL single_count: got %0d expected 1", vcyc_q.size());
    else n_pass++;
    n_checks++;
    if (vcyc_q.size() == 0 || vcyc_q[0] != p + LAT)
      $display("FAIL single_latency: got edge %0d expected %0d",
               (vcyc_q.size() == 0) ? -1 : vcyc_q[0], p + LAT);
    else n_pass++;
    n_checks++;
    if (vdata_q.size() == 0 || vdata_q[0] !== 8'hA5)
      $display("FAIL single_data: got %h expected a5", (vdata_q.size() == 0) ? 8'hxx : vdata_q[0]);
    else n_pass++;
    n_checks++;
    if (out_sum !== ref_sum || ecyc_q.size() != 0)
      $display("FAIL single_sum: got %h err=%0d expected %h err=0", out_sum, ecyc_q.size(), ref_sum);
    else n_pass++;
  endtask

  task automatic test_glitch();
    int p;
    clear_mon();
    rx = 1'b0;
    tick(1);
    rx = 1'b1;
    tick(12);
    n_checks++;
    if (vcyc_q.size() != 0 || ecyc_q.size() != 0 || dbg_state !== 3'd0)
      $display("FAIL glitch_reject: got %0d valid %0d error state %0d expected 0 0 0",
               vcyc_q.size(), ecyc_q.size(), dbg_state);
    else n_pass++;
    drive_frame(8'h3C, 1'b1, p);
    ref_sum += 32'h3C; ref_last = 8'h3C;
    tick(3);
    n_checks++;
    if (vdata_q.size() != 1 || vdata_q[0] !== 8'h3C || out_sum !== ref_sum)
      $display("FAIL glitch_next_frame: got n=%0d d=%h s=%h expected n=1 d=3c s=%h",
               vdata_q.size(), out_data, out_sum, ref_sum);
    else n_pass++;
  endtask

  task automatic test_framing();
    int p;
    clear_mon();
    drive_frame(8'h3C, 1'b0, p);   // stop bit low; line stays low
    tick(50);
    rx = 1'b1;
    tick(5);
    n_checks++;
    if (ecyc_q.size() != 1 || ecyc_q[0] != p + LAT)
      $display("FAIL frame_error_pulse: got n=%0d edge=%0d expected n=1 edge=%0d",
               ecyc_q.size(), (ecyc_q.size() == 0) ? -1 : ecyc_q[0], p + LAT);
    else n_pass++;
    n_checks++;
    if (vcyc_q.size() != 0 || out_data !== ref_last || out_sum !== ref_sum)
      $display("FAIL frame_error_hold: got n=%0d d=%h s=%h expected n=0 d=%h s=%h",
               vcyc_q.size(), out_data, out_sum, ref_last, ref_sum);
    else n_pass++;
    clear_mon();
    drive_frame(8'h01, 1'b1, p);
    ref_sum += 32'h01; ref_last = 8'h01;
    tick(3);
    n_checks++;
    if (vdata_q.size() != 1 || vdata_q[0] !== 8'h01 || out_sum !== ref_sum || ecyc_q.size() != 0)
      $display("FAIL frame_recover: got n=%0d d=%h s=%h expected n=1 d=01 s=%h",
               vdata_q.size(), out_data, out_sum, ref_sum);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int p0, p1;
    do_reset();
    clear_mon();
    drive_frame(8'h00, 1'b1, p0);
    drive_frame(8'hFF, 1'b1, p1);
    ref_sum += 32'h00 + 32'hFF; ref_last = 8'hFF;
    tick(3);
    n_checks++;
    if (vcyc_q.size() != 2 || vcyc_q[1] - vcyc_q[0] != 10 * CPB)
      $display("FAIL b2b_spacing: got n=%0d gap=%0d expected n=2 gap=%0d", vcyc_q.size(),
               (vcyc_q.size() == 2) ? vcyc_q[1] - vcyc_q[0] : -1, 10 * CPB);
    else n_pass++;
    n_checks++;
    if (vdata_q.size() != 2 || vdata_q[0] !== 8'h00 || vdata_q[1] !== 8'hFF)
      $display("FAIL b2b_data: got n=%0d last=%h expected 00 then ff", vdata_q.size(), out_data);
    else n_pass++;
    n_checks++;
    if (out_sum !== 32'h0000_00FF)
      $display("FAIL b2b_sum: got %h expected 000000ff", out_sum);
    else n_pass++;
  endtask

  task automatic test_reset_mid_frame();
    int p;
    logic [7:0] b;
    b = 8'h5A;
    clear_mon();
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = b[4];
    tick(CPB / 2);
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_error, out_data, out_sum} !== 42'd0 || dbg_state !== 3'd0)
      $display("FAIL midreset_outputs: got d=%h s=%h st=%0d expected all zero",
               out_data, out_sum, dbg_state);
    else n_pass++;
    ref_sum = '0; ref_last = '0;
    tick(2);
    rx = 1'b1;
    rst_n = 1'b1;
    tick(5 * CPB);
    n_checks++;
    if (vcyc_q.size() != 0 || ecyc_q.size() != 0)
      $display("FAIL midreset_no_pulse: got %0d valid %0d error expected 0 0",
               vcyc_q.size(), ecyc_q.size());
    else n_pass++;
    drive_frame(8'h7E, 1'b1, p);
    ref_sum += 32'h7E; ref_last = 8'h7E;
    tick(3);
    n_checks++;
    if (vdata_q.size() != 1 || vdata_q[0] !== 8'h7E || out_sum !== ref_sum)
      $display("FAIL midreset_next: got n=%0d d=%h s=%h expected n=1 d=7e s=%h",
               vdata_q.size(), out_data, out_sum, ref_sum);
    else n_pass++;
  endtask

  task automatic send_checked(input logic [7:0] b);
    int p;
    drive_frame(b, 1'b1, p);
    exp_q.push_back(b);
    exp_cyc_q.push_back(p + LAT);
    ref_sum += {24'b0, b};
    ref_last = b;
    tick($urandom_range(0, 6));
  endtask

  task automatic test_loopback();
    int         n_ff;
    int         idx;
    logic [7:0] b;
    clear_mon();
    exp_q.delete();
    exp_cyc_q.delete();
    send_checked(8'h48);
    send_checked(8'h69);
    tick(3);
    // Preload the checksum near the top so the 0xFF run wraps it.
    force dut.sum_q = 32'hFFFF_FF00;
    tick(1);
    release dut.sum_q;
    tick(1);
    ref_sum = 32'hFFFF_FF00;
    n_checks++;
    if (out_sum !== ref_sum) $display("FAIL loop_preload: got %h expected %h", out_sum, ref_sum);
    else n_pass++;
    n_ff = $urandom_range(3, 6);
    for (int i = 0; i < n_ff; i++) send_checked(8'hFF);
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(0, 255));
      send_checked(b);
    end
    tick(3);
    n_checks++;
    if (vdata_q.size() != exp_q.size())
      $display("FAIL loop_count: got %0d expected %0d", vdata_q.size(), exp_q.size());
    else n_pass++;
    idx = 0;
    while (exp_q.size() != 0 && vdata_q.size() != 0) begin
      n_checks++;
      if (vdata_q[0] !== exp_q[0] || vcyc_q[0] != exp_cyc_q[0])
        $display("FAIL loop_byte%0d: got %h at edge %0d expected %h at edge %0d",
                 idx, vdata_q[0], vcyc_q[0], exp_q[0], exp_cyc_q[0]);
      else n_pass++;
      void'(vdata_q.pop_front());
      void'(vcyc_q.pop_front());
      void'(exp_q.pop_front());
      void'(exp_cyc_q.pop_front());
      idx++;
    end
    n_checks++;
    if (out_sum !== ref_sum || out_data !== ref_last)
      $display("FAIL loop_sum: got s=%h d=%h expected s=%h d=%h", out_sum, out_data, ref_sum, ref_last);
    else n_pass++;
    n_checks++;
    if (ecyc_q.size() != 0 || both_cnt != 0)
      $display("FAIL loop_no_error: got err=%0d both=%0d expected 0 0", ecyc_q.size(), both_cnt);
    else n_pass++;
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_back_to_back();
    test_reset_mid_frame();
    test_loopback();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_uart_rx
